// File: rtl/sw_pkg.sv
// Shared constants for the switch debouncer: channel count and per-channel FSM state encoding.
package sw_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef logic [1:0] sw_state_t;

    localparam sw_state_t ST_LOW      = 2'd0;
    localparam sw_state_t ST_RISE_CHK = 2'd1;
    localparam sw_state_t ST_HIGH     = 2'd2;
    localparam sw_state_t ST_FALL_CHK = 2'd3;

    // Width of the per-channel tick counters; must hold LONG_TICKS.
    function automatic int unsigned sw_cnt_width(input int unsigned long_ticks);
        return (long_ticks < 1) ? 1 : $clog2(long_ticks + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One debounce channel: tick-sampled qualification FSM, registered level and edge pulses.
// Long-press pulse logic exists only when SW_DEBOUNCE_LONGPRESS_EN is defined.
module sw_debounce_ch
    import sw_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 20,
    parameter int unsigned LONG_TICKS   = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic sample_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);

    localparam int unsigned   CW         = sw_cnt_width(LONG_TICKS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_STABLE = CW'(STABLE_TICKS);
    localparam bit            SINGLE     = (STABLE_TICKS == 1);

    sw_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          accept;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    assign accept  = (cnt_inc == CNT_STABLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick_i) begin
            case (state_q)
                ST_LOW: begin
                    if (sample_i) begin
                        if (SINGLE) begin
                            state_d = ST_HIGH;
                            cnt_d   = '0;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ST_RISE_CHK;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_RISE_CHK: begin
                    if (sample_i) begin
                        if (accept) begin
                            state_d = ST_HIGH;
                            cnt_d   = '0;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Bounce: drop the qualification silently.
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end
                end
                ST_HIGH: begin
                    if (!sample_i) begin
                        if (SINGLE) begin
                            state_d = ST_LOW;
                            cnt_d   = '0;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = ST_FALL_CHK;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_FALL_CHK: begin
                    if (!sample_i) begin
                        if (accept) begin
                            state_d = ST_LOW;
                            cnt_d   = '0;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef SW_DEBOUNCE_LONGPRESS_EN
    localparam logic [CW-1:0] CNT_LONG = CW'(LONG_TICKS);

    logic [CW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Counts ticks spent in HIGH since entry; saturates so the pulse fires once per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q != ST_HIGH || state_d != ST_HIGH) begin
            hold_d = '0;
        end else if (tick_i && hold_q != CNT_LONG) begin
            hold_d = hold_q + CNT_ONE;
            long_d = (hold_q + CNT_ONE == CNT_LONG);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Four-channel switch debouncer: 2-flop synchronisers, shared tick prescaler, per-channel FSMs.
// Define SW_DEBOUNCE_LONGPRESS_EN to build the long-press pulse outputs.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 125000000,
    parameter int unsigned TICK_HZ      = 1000,
    parameter int unsigned STABLE_TICKS = 20,
    parameter int unsigned LONG_TICKS   = 1000
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sw_in,
    output logic [NUM_CH-1:0] sw_level,
    output logic [NUM_CH-1:0] sw_rise,
    output logic [NUM_CH-1:0] sw_fall,
    output logic [NUM_CH-1:0] sw_long
);

    localparam int unsigned   DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned   PW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    if (DIV < 2) begin : gen_bad_div
        $error("sw_debounce: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (STABLE_TICKS < 1) begin : gen_bad_stable
        $error("sw_debounce: STABLE_TICKS must be at least 1");
    end
    if (LONG_TICKS <= STABLE_TICKS) begin : gen_bad_long
        $error("sw_debounce: LONG_TICKS must exceed STABLE_TICKS");
    end

    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic              tick;

    always_comb begin
        tick    = (presc_q == TERM);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        sw_debounce_ch #(
            .STABLE_TICKS(STABLE_TICKS),
            .LONG_TICKS  (LONG_TICKS)
        ) u_ch (
            .clk_i   (clk_in),
            .rst_i   (rst),
            .tick_i  (tick),
            .sample_i(sync2_q[g]),
            .level_o (sw_level[g]),
            .rise_o  (sw_rise[g]),
            .fall_o  (sw_fall[g]),
            .long_o  (sw_long[g])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed vector table, hand-written corner sequences and a
// randomized run against a run-length reference model of the debounce rules.
module tb_sw_debounce;

    localparam int unsigned CLK_HZ  = 8;
    localparam int unsigned TICK_HZ = 2;
    localparam int unsigned STABLE  = 3;
    localparam int unsigned LONG    = 5;
    localparam int unsigned DIV     = CLK_HZ / TICK_HZ;

`ifdef SW_DEBOUNCE_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif
    localparam logic [3:0] LE = LP_EN ? 4'hF : 4'h0;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] sw_in  = 4'hF;
    logic [3:0] sw_level, sw_rise, sw_fall, sw_long;

    int n_tests = 0;
    int n_fail  = 0;

    sw_debounce #(
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .STABLE_TICKS(STABLE),
        .LONG_TICKS  (LONG)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_level(sw_level),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .sw_long (sw_long)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: accepted level flips after STABLE consecutive differing tick samples.
    int         m_div;
    logic [3:0] m_s1, m_s2, m_level, m_rise, m_fall, m_long;
    int         m_run  [4];
    int         m_hold [4];

    always @(posedge clk_in) begin
        if (rst) begin
            m_div = 0; m_s1 = 4'h0; m_s2 = 4'h0; m_level = 4'h0;
            m_rise = 4'h0; m_fall = 4'h0; m_long = 4'h0;
            for (int c = 0; c < 4; c++) begin m_run[c] = 0; m_hold[c] = 0; end
        end else begin
            m_rise = 4'h0; m_fall = 4'h0; m_long = 4'h0;
            if (m_div == DIV - 1) begin
                for (int c = 0; c < 4; c++) begin
                    if (m_s2[c] != m_level[c]) begin
                        m_run[c]++;
                        m_hold[c] = 0;
                        if (m_run[c] == STABLE) begin
                            m_level[c] = m_s2[c];
                            if (m_s2[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
                            m_run[c] = 0;
                        end
                    end else begin
                        if (m_level[c] && m_run[c] == 0) begin
                            if (m_hold[c] < LONG) begin
                                m_hold[c]++;
                                if (m_hold[c] == LONG) m_long[c] = LP_EN;
                            end
                        end else begin
                            m_hold[c] = 0;
                        end
                        m_run[c] = 0;
                    end
                end
            end
            m_div = (m_div + 1) % DIV;
            m_s2  = m_s1;
            m_s1  = sw_in;
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        int         cycles;
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] lng;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int rise_cnt, rise_at, long_cnt, long_at, fall_cnt, fall_at;
        logic [3:0] other;
        int hold_left [4];
        int rst_left;

        // Comments give the posedge count since reset release at which the row is checked.
        tbl[0]  = '{1'b1, 4'hF, 10, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'hF, 11, 4'h0, 4'h0, 4'h0, 4'h0}; // 11
        tbl[2]  = '{1'b0, 4'hF, 1,  4'hF, 4'hF, 4'h0, 4'h0}; // 12: third tick accepted
        tbl[3]  = '{1'b0, 4'hF, 1,  4'hF, 4'h0, 4'h0, 4'h0}; // 13
        tbl[4]  = '{1'b0, 4'hF, 18, 4'hF, 4'h0, 4'h0, 4'h0}; // 31
        tbl[5]  = '{1'b0, 4'hF, 1,  4'hF, 4'h0, 4'h0, LE};   // 32: fifth tick in HIGH
        tbl[6]  = '{1'b0, 4'hF, 1,  4'hF, 4'h0, 4'h0, 4'h0}; // 33
        tbl[7]  = '{1'b0, 4'h0, 10, 4'hF, 4'h0, 4'h0, 4'h0}; // 43
        tbl[8]  = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'hF, 4'h0}; // 44
        tbl[9]  = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0}; // 45
        tbl[10] = '{1'b0, 4'h1, 8,  4'h0, 4'h0, 4'h0, 4'h0}; // 53: two qualifying ticks
        tbl[11] = '{1'b0, 4'h0, 12, 4'h0, 4'h0, 4'h0, 4'h0}; // 65: bounce rejected
        tbl[12] = '{1'b0, 4'h2, 8,  4'h0, 4'h0, 4'h0, 4'h0}; // 73: ch1 in RISE_CHK
        tbl[13] = '{1'b1, 4'h2, 2,  4'h0, 4'h0, 4'h0, 4'h0}; // reset aborts check
        tbl[14] = '{1'b0, 4'h2, 11, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[15] = '{1'b0, 4'h2, 1,  4'h2, 4'h2, 4'h0, 4'h0}; // prescaler restarted at 0
        tbl[16] = '{1'b0, 4'h2, 1,  4'h2, 4'h0, 4'h0, 4'h0};

        for (int i = 0; i < 17; i++) begin
            rst   = tbl[i].rst;
            sw_in = tbl[i].sw;
            repeat (tbl[i].cycles) @(negedge clk_in);
            chk($sformatf("vec%0d_level", i), sw_level, tbl[i].level);
            chk($sformatf("vec%0d_rise", i),  sw_rise,  tbl[i].rise);
            chk($sformatf("vec%0d_fall", i),  sw_fall,  tbl[i].fall);
            chk($sformatf("vec%0d_long", i),  sw_long,  tbl[i].lng);
        end

        // Long hold on channel 2 only, then release.
        rst = 1'b1; sw_in = 4'h0;
        repeat (2) @(negedge clk_in);
        rst = 1'b0; sw_in = 4'h4;
        rise_cnt = 0; rise_at = -1; long_cnt = 0; long_at = -1; other = 4'h0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk_in);
            if (sw_rise[2]) begin rise_cnt++; rise_at = n; end
            if (sw_long[2]) begin long_cnt++; long_at = n; end
            other |= (sw_level | sw_rise | sw_fall | sw_long) & 4'hB;
        end
        chk_int("hold_rise_count", rise_cnt, 1);
        chk_int("hold_rise_cycle", rise_at, 12);
        chk_int("hold_long_count", long_cnt, LP_EN ? 1 : 0);
        chk_int("hold_long_cycle", long_at, LP_EN ? 32 : -1);
        chk("hold_other_bits", other, 4'h0);
        chk("hold_level", sw_level, 4'h4);
        sw_in = 4'h0;
        fall_cnt = 0; fall_at = -1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk_in);
            if (sw_fall[2]) begin fall_cnt++; fall_at = n; end
            if (sw_rise[2] || sw_long[2]) other[2] = 1'b1;
        end
        chk_int("release_fall_count", fall_cnt, 1);
        chk_int("release_fall_cycle", fall_at, 12);
        chk("release_level", sw_level, 4'h0);
        chk("release_no_extra", other, 4'h0);

        // Randomized bouncing on all channels with occasional resets.
        rst = 1'b1; sw_in = 4'h0;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        rst_left = 0;
        for (int b = 0; b < 4; b++) hold_left[b] = $urandom_range(1, 18);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk_in);
            chk("rnd_level", sw_level, m_level);
            chk("rnd_rise",  sw_rise,  m_rise);
            chk("rnd_fall",  sw_fall,  m_fall);
            chk("rnd_long",  sw_long,  m_long);
            chk("rnd_rise_and_fall", sw_rise & sw_fall, 4'h0);
            if (rst_left == 0 && $urandom_range(0, 799) == 0) rst_left = $urandom_range(1, 3);
            rst = (rst_left != 0);
            if (rst_left != 0) rst_left--;
            for (int b = 0; b < 4; b++) begin
                hold_left[b]--;
                if (hold_left[b] <= 0) begin
                    sw_in[b] = ~sw_in[b];
                    hold_left[b] = ($urandom_range(0, 4) == 0) ? $urandom_range(30, 70)
                                                               : $urandom_range(1, 18);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
